// File: rtl/wb_commit_unit_pkg.sv
// Shared definitions for the multi-lane writeback/commit stage.
//   lane_t   : one 80-bit MEM->WB lane, MSB->LSB
//              valid[79] pc[78:47] gr_we[46] dest[45:41] wdata[40:9]
//              ex[8] ecode[7:2] ertn[1] refetch[0]
//   trace_t  : one 69-bit debug trace entry {pc, dest, wdata}
//   flush cause bit positions inside the 3-bit {ex, ertn, refetch} vector
//   a few common LoongArch ecode values
package wb_commit_unit_pkg;

  localparam int LANE_W  = 80;
  localparam int RF_W    = 39;
  localparam int TRACE_W = 69;

  localparam int CAUSE_EX      = 2;
  localparam int CAUSE_ERTN    = 1;
  localparam int CAUSE_REFETCH = 0;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] wdata;
    logic        ex;
    logic [5:0]  ecode;
    logic        ertn;
    logic        refetch;
  } lane_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] wdata;
  } trace_t;

  // A lane redirects the pipeline when it is valid and raises any flush flag.
  function automatic logic lane_flushes(input lane_t l);
    return l.valid && (l.ex || l.ertn || l.refetch);
  endfunction

  // One-hot cause; a lane raising several flags reports ex, then ertn, then refetch.
  function automatic logic [2:0] lane_cause(input lane_t l);
    logic [2:0] c;
    c = 3'b000;
    if (l.ex)           c[CAUSE_EX]      = 1'b1;
    else if (l.ertn)    c[CAUSE_ERTN]    = 1'b1;
    else if (l.refetch) c[CAUSE_REFETCH] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/wb_commit_unit_trace_fifo.sv
// trace_fifo: multi-push, single-pop FIFO feeding the debug trace port.
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push_cnt    : number of entries pushed this cycle (0..PUSH_W)
//   push_data   : entry p at [p*WIDTH +: WIDTH], entries 0..push_cnt-1 valid
//   free_cnt    : DEPTH - occupancy; the producer never pushes more than this
//   out_valid   : registered head entry is being presented this cycle
//   out_data    : registered head entry
// The FIFO pops one entry every cycle it is non-empty; the popped head is
// captured into the output register, so an entry is visible no earlier than
// the cycle after the one in which it was written.
module trace_fifo
  import wb_commit_unit_pkg::*;
#(
  parameter int WIDTH  = TRACE_W,
  parameter int DEPTH  = 8,
  parameter int PUSH_W = 2,
  localparam int PW    = $clog2(PUSH_W + 1),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PW-1:0]           push_cnt,
  input  logic [PUSH_W*WIDTH-1:0] push_data,
  output logic [CW-1:0]           free_cnt,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             pop;

  assign pop      = (count != '0);
  // Free space ignores this cycle's pop so a push can never overrun the head.
  assign free_cnt = CW'(DEPTH) - count;

  // Storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    for (int p = 0; p < PUSH_W; p++) begin
      if (!reset && (p < int'(push_cnt))) begin
        mem[wr_ptr + AW'(p)] <= push_data[p*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      wr_ptr    <= wr_ptr + AW'(push_cnt);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count     <= count + CW'(push_cnt) - CW'(pop);
      out_valid <= pop;
      out_data  <= pop ? mem[rd_ptr] : '0;
    end
  end

endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: COMMIT_W-lane writeback/commit stage.
//   clk, reset        : clock, synchronous active-high reset
//   ws_allowin        : stage accepts a MEM bundle this cycle
//   ms_to_ws_valid    : MEM bundle valid
//   ms_to_ws_bus      : lane i at [i*80 +: 80], lane 0 oldest (layout in lane_t)
//   rf_bus            : lane i at [i*39 +: 39] = {ws_valid, rf_we, waddr, wdata}
//   wb_flush*         : flush pulse with one-hot {ex,ertn,refetch}, ecode and pc
//   debug_wb_*        : single-lane trace of committed writes, in program order
//
// Handshake: a bundle moves MEM->WB on a clock edge where ms_to_ws_valid and
// ws_allowin are both high. ws_allowin = !ws_valid || ws_ready_go, and
// ws_ready_go is high when the trace FIFO has room for every write this bundle
// would push. While ws_ready_go is low the bundle holds and nothing commits.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int COMMIT_W    = 2,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ws_allowin,
  input  logic                       ms_to_ws_valid,
  input  logic [COMMIT_W*LANE_W-1:0] ms_to_ws_bus,
  output logic [COMMIT_W*RF_W-1:0]   rf_bus,
  output logic                       wb_flush,
  output logic [2:0]                 wb_flush_cause,
  output logic [5:0]                 wb_flush_ecode,
  output logic [31:0]                wb_flush_pc,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_we,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  localparam int PW = $clog2(COMMIT_W + 1);
  localparam int CW = $clog2(TRACE_DEPTH + 1);

  lane_t                      in_lane [COMMIT_W];
  lane_t                      ws_lane [COMMIT_W];
  logic                       ws_valid;
  logic                       ws_ready_go;

  logic [COMMIT_W-1:0]        live;
  logic [COMMIT_W-1:0]        wants_write;
  logic [COMMIT_W-1:0]        rf_we;
  logic [PW-1:0]              need_cnt;
  logic                       flush_found;
  logic [2:0]                 flush_cause_c;
  logic [5:0]                 flush_ecode_c;
  logic [31:0]                flush_pc_c;

  logic [PW-1:0]              push_cnt;
  logic [COMMIT_W*TRACE_W-1:0] push_data;
  logic [CW-1:0]              free_cnt;
  logic                       trace_valid;
  trace_t                     trace_head;

  always_comb begin
    for (int i = 0; i < COMMIT_W; i++) begin
      in_lane[i] = lane_t'(ms_to_ws_bus[i*LANE_W +: LANE_W]);
    end
  end

  // Bundle register and stage valid
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
      for (int i = 0; i < COMMIT_W; i++) ws_lane[i] <= '0;
    end else begin
      // Upstream is flushed together with us, so the incoming bundle is dropped.
      if (wb_flush)        ws_valid <= 1'b0;
      else if (ws_allowin) ws_valid <= ms_to_ws_valid;
      if (ms_to_ws_valid && ws_allowin) begin
        for (int i = 0; i < COMMIT_W; i++) ws_lane[i] <= in_lane[i];
      end
    end
  end

  // Flush lane search and write demand. Lanes older than the first flushing
  // lane are "live"; the flushing lane and everything younger are killed.
  always_comb begin
    live          = '0;
    wants_write   = '0;
    need_cnt      = '0;
    flush_found   = 1'b0;
    flush_cause_c = 3'b000;
    flush_ecode_c = 6'd0;
    flush_pc_c    = 32'd0;
    for (int i = 0; i < COMMIT_W; i++) begin
      live[i] = ws_valid && ws_lane[i].valid && !flush_found;
      if (live[i] && lane_flushes(ws_lane[i])) begin
        live[i]       = 1'b0;
        flush_found   = 1'b1;
        flush_cause_c = lane_cause(ws_lane[i]);
        flush_ecode_c = ws_lane[i].ecode;
        flush_pc_c    = ws_lane[i].pc;
      end
      wants_write[i] = live[i] && ws_lane[i].gr_we && (ws_lane[i].dest != 5'd0);
      if (wants_write[i]) need_cnt = need_cnt + PW'(1);
    end
  end

  // Demand is computed without ws_ready_go, which keeps this loop-free.
  assign ws_ready_go = (32'(free_cnt) >= 32'(need_cnt));
  assign ws_allowin  = !ws_valid || ws_ready_go;

  // Register-file writes and trace packing. Every committing write is traced,
  // including ones shadowed by a younger same-dest lane, so the trace reads as
  // if the lanes had retired one at a time.
  always_comb begin
    int   idx;
    logic overridden;
    idx        = 0;
    overridden = 1'b0;
    rf_we      = '0;
    push_data  = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (wants_write[i] && ws_ready_go) begin
        push_data[idx*TRACE_W +: TRACE_W] = {ws_lane[i].pc, ws_lane[i].dest, ws_lane[i].wdata};
        idx        = idx + 1;
        overridden = 1'b0;
        for (int j = i + 1; j < COMMIT_W; j++) begin
          if (wants_write[j] && (ws_lane[j].dest == ws_lane[i].dest)) overridden = 1'b1;
        end
        rf_we[i] = !overridden;
      end
    end
    push_cnt = ws_ready_go ? need_cnt : '0;
  end

  always_comb begin
    rf_bus = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      rf_bus[i*RF_W +: RF_W] = {ws_valid && ws_lane[i].valid, rf_we[i],
                                ws_lane[i].dest, ws_lane[i].wdata};
    end
  end

  assign wb_flush       = ws_ready_go && flush_found;
  assign wb_flush_cause = wb_flush ? flush_cause_c : 3'b000;
  assign wb_flush_ecode = wb_flush ? flush_ecode_c : 6'd0;
  assign wb_flush_pc    = wb_flush ? flush_pc_c    : 32'd0;

  trace_fifo #(
    .WIDTH  (TRACE_W),
    .DEPTH  (TRACE_DEPTH),
    .PUSH_W (COMMIT_W)
  ) u_trace_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .free_cnt  (free_cnt),
    .out_valid (trace_valid),
    .out_data  (trace_head)
  );

  assign debug_wb_pc       = trace_head.pc;
  assign debug_wb_rf_we    = {4{trace_valid}};
  assign debug_wb_rf_wnum  = trace_head.dest;
  assign debug_wb_rf_wdata = trace_head.wdata;

endmodule

// File: tb/tb_wb_commit_unit.sv
module tb_wb_commit_unit;

  localparam int COMMIT_W    = 2;
  localparam int TRACE_DEPTH = 4;
  localparam int LW          = 80;
  localparam int NV          = 9;

  logic                     clk;
  logic                     reset;
  logic                     ws_allowin;
  logic                     ms_to_ws_valid;
  logic [COMMIT_W*LW-1:0]   ms_to_ws_bus;
  logic [COMMIT_W*39-1:0]   rf_bus;
  logic                     wb_flush;
  logic [2:0]               wb_flush_cause;
  logic [5:0]               wb_flush_ecode;
  logic [31:0]              wb_flush_pc;
  logic [31:0]              debug_wb_pc;
  logic [3:0]               debug_wb_rf_we;
  logic [4:0]               debug_wb_rf_wnum;
  logic [31:0]              debug_wb_rf_wdata;

  int tests;
  int fails;
  logic [68:0] exp_q[$];

  typedef struct {
    logic [79:0] l0;
    logic [79:0] l1;
    logic [1:0]  we;
    logic        flush;
    logic [2:0]  cause;
    logic [31:0] fpc;
    logic [5:0]  fecode;
    int          ntr;
    logic [68:0] t0;
    logic [68:0] t1;
  } vec_t;

  vec_t vecs[NV];

  wb_commit_unit #(
    .COMMIT_W    (COMMIT_W),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .rf_bus            (rf_bus),
    .wb_flush          (wb_flush),
    .wb_flush_cause    (wb_flush_cause),
    .wb_flush_ecode    (wb_flush_ecode),
    .wb_flush_pc       (wb_flush_pc),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] mk(input logic v, input logic [31:0] pc, input logic we,
                                     input logic [4:0] dest, input logic [31:0] data,
                                     input logic ex, input logic [5:0] ecode,
                                     input logic ertn, input logic refetch);
    return {v, pc, we, dest, data, ex, ecode, ertn, refetch};
  endfunction

  function automatic logic [68:0] tr(input logic [31:0] pc, input logic [4:0] dest,
                                     input logic [31:0] data);
    return {pc, dest, data};
  endfunction

  function automatic vec_t mkv(input logic [79:0] l0, input logic [79:0] l1, input logic [1:0] we,
                               input logic flush, input logic [2:0] cause, input logic [31:0] fpc,
                               input logic [5:0] fecode, input int ntr,
                               input logic [68:0] t0, input logic [68:0] t1);
    vec_t v;
    v.l0 = l0; v.l1 = l1; v.we = we; v.flush = flush; v.cause = cause;
    v.fpc = fpc; v.fecode = fecode; v.ntr = ntr; v.t0 = t0; v.t1 = t1;
    return v;
  endfunction

  // {lane1 valid, lane1 rf_we, lane0 valid, lane0 rf_we}
  function automatic logic [3:0] rf_flags();
    return {rf_bus[77], rf_bus[76], rf_bus[38], rf_bus[37]};
  endfunction

  // Scoreboard
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_trace();
    logic [68:0] e;
    if (debug_wb_rf_we != 4'h0) begin
      check("trace_we", 128'(debug_wb_rf_we), 128'(4'hf));
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL trace_extra: got pc 0x%0h r%0d=0x%0h, expected no entry",
                 debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
      end else begin
        e = exp_q.pop_front();
        check("trace_entry", 128'({debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata}), 128'(e));
      end
    end
  endtask

  // Driver: inputs change at posedge+1, outputs are sampled at posedge+2 or negedge.
  task automatic clk_cycle();
    @(negedge clk);
    check_trace();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int cyc;
    logic stalled;
    logic [77:0] erf;
    tests = 0;
    fails = 0;

    vecs[0] = mkv(mk(1, 32'h1c000000, 1, 5'd4, 32'h11, 0, 6'h00, 0, 0),
                  mk(1, 32'h1c000004, 1, 5'd5, 32'h22, 0, 6'h00, 0, 0),
                  2'b11, 0, 3'b000, 32'h0, 6'h00, 2,
                  tr(32'h1c000000, 5'd4, 32'h11), tr(32'h1c000004, 5'd5, 32'h22));
    vecs[1] = mkv(mk(1, 32'h1c000000, 1, 5'd4, 32'h11, 0, 6'h00, 0, 0),
                  mk(1, 32'h1c000004, 1, 5'd5, 32'h22, 1, 6'h0b, 0, 0),
                  2'b01, 1, 3'b100, 32'h1c000004, 6'h0b, 1,
                  tr(32'h1c000000, 5'd4, 32'h11), '0);
    vecs[2] = mkv(mk(1, 32'h1c000020, 1, 5'd6, 32'h33, 0, 6'h00, 0, 1),
                  mk(1, 32'h1c000024, 1, 5'd7, 32'h44, 1, 6'h0c, 0, 0),
                  2'b00, 1, 3'b001, 32'h1c000020, 6'h00, 0, '0, '0);
    vecs[3] = mkv(mk(1, 32'h1c000030, 1, 5'd7, 32'hA, 0, 6'h00, 0, 0),
                  mk(1, 32'h1c000034, 1, 5'd7, 32'hB, 0, 6'h00, 0, 0),
                  2'b10, 0, 3'b000, 32'h0, 6'h00, 2,
                  tr(32'h1c000030, 5'd7, 32'hA), tr(32'h1c000034, 5'd7, 32'hB));
    vecs[4] = mkv(mk(1, 32'h1c000040, 1, 5'd8, 32'h55, 1, 6'h0c, 1, 1),
                  mk(1, 32'h1c000044, 1, 5'd9, 32'h66, 0, 6'h00, 0, 0),
                  2'b00, 1, 3'b100, 32'h1c000040, 6'h0c, 0, '0, '0);
    vecs[5] = mkv(mk(1, 32'h1c000050, 1, 5'd10, 32'h77, 0, 6'h00, 0, 0),
                  mk(1, 32'h1c000054, 1, 5'd11, 32'h88, 0, 6'h00, 1, 1),
                  2'b01, 1, 3'b010, 32'h1c000054, 6'h00, 1,
                  tr(32'h1c000050, 5'd10, 32'h77), '0);
    vecs[6] = mkv(mk(1, 32'h1c000060, 1, 5'd0, 32'h99, 0, 6'h00, 0, 0),
                  mk(1, 32'h1c000064, 1, 5'd3, 32'haa, 0, 6'h00, 0, 0),
                  2'b10, 0, 3'b000, 32'h0, 6'h00, 1,
                  tr(32'h1c000064, 5'd3, 32'haa), '0);
    vecs[7] = mkv(mk(0, 32'h1c000070, 1, 5'd12, 32'hbb, 1, 6'h08, 0, 0),
                  mk(1, 32'h1c000074, 1, 5'd13, 32'hcc, 0, 6'h00, 0, 0),
                  2'b10, 0, 3'b000, 32'h0, 6'h00, 1,
                  tr(32'h1c000074, 5'd13, 32'hcc), '0);
    vecs[8] = mkv(mk(1, 32'h1c000080, 0, 5'd14, 32'hdd, 0, 6'h00, 0, 0),
                  mk(1, 32'h1c000084, 0, 5'd15, 32'hee, 0, 6'h00, 0, 0),
                  2'b00, 0, 3'b000, 32'h0, 6'h00, 0, '0, '0);

    // Reset state
    reset = 1'b1;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_allowin", 128'(ws_allowin), 128'(1'b1));
    check("rst_rf_bus", 128'(rf_bus), 128'(0));
    check("rst_flush", 128'({wb_flush, wb_flush_cause, wb_flush_ecode, wb_flush_pc}), 128'(0));
    check("rst_debug", 128'({debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}), 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    clk_cycle();

    // Table-driven single bundles, FIFO drained between vectors
    for (int i = 0; i < NV; i++) begin
      ms_to_ws_bus = {vecs[i].l1, vecs[i].l0};
      ms_to_ws_valid = 1'b1;
      #1;
      check($sformatf("v%0d_allowin", i), 128'(ws_allowin), 128'(1'b1));
      clk_cycle();
      ms_to_ws_valid = 1'b0;
      #1;
      erf = {vecs[i].l1[79], vecs[i].we[1], vecs[i].l1[45:41], vecs[i].l1[40:9],
             vecs[i].l0[79], vecs[i].we[0], vecs[i].l0[45:41], vecs[i].l0[40:9]};
      check($sformatf("v%0d_rf_bus", i), 128'(rf_bus), 128'(erf));
      check($sformatf("v%0d_flush", i), 128'(wb_flush), 128'(vecs[i].flush));
      if (vecs[i].flush) begin
        check($sformatf("v%0d_cause", i), 128'(wb_flush_cause), 128'(vecs[i].cause));
        check($sformatf("v%0d_fpc", i), 128'(wb_flush_pc), 128'(vecs[i].fpc));
        check($sformatf("v%0d_ecode", i), 128'(wb_flush_ecode), 128'(vecs[i].fecode));
      end
      if (vecs[i].ntr > 0) exp_q.push_back(vecs[i].t0);
      if (vecs[i].ntr > 1) exp_q.push_back(vecs[i].t1);
      clk_cycle();
      #1;
      check($sformatf("v%0d_after_flags", i), 128'(rf_flags()), 128'(4'b0000));
      repeat (4) clk_cycle();
    end
    check("vec_trace_drained", 128'(exp_q.size()), 128'(0));

    // Flush drops the bundle MEM offers in the same cycle
    ms_to_ws_bus = {mk(1, 32'h1c000104, 1, 5'd5, 32'h5678, 1, 6'h0b, 0, 0),
                    mk(1, 32'h1c000100, 1, 5'd4, 32'h1234, 0, 6'h00, 0, 0)};
    ms_to_ws_valid = 1'b1;
    clk_cycle();
    ms_to_ws_bus = {mk(1, 32'h1c000204, 1, 5'd21, 32'hbeef, 0, 6'h00, 0, 0),
                    mk(1, 32'h1c000200, 1, 5'd20, 32'hcafe, 0, 6'h00, 0, 0)};
    #1;
    check("drop_flush", 128'(wb_flush), 128'(1'b1));
    check("drop_allowin", 128'(ws_allowin), 128'(1'b1));
    exp_q.push_back(tr(32'h1c000100, 5'd4, 32'h1234));
    clk_cycle();
    ms_to_ws_valid = 1'b0;
    #1;
    check("drop_flags", 128'(rf_flags()), 128'(4'b0000));
    check("drop_no_flush", 128'(wb_flush), 128'(1'b0));
    repeat (4) clk_cycle();
    check("drop_trace_drained", 128'(exp_q.size()), 128'(0));

    // Back-to-back dual-write bundles against a 4-entry trace FIFO
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    while (k < 6 && cyc < 100) begin
      ms_to_ws_bus = {mk(1, 32'h1c001004 + 32'(8*k), 1, 5'(k + 17), 32'h200 + 32'(k), 0, 6'h00, 0, 0),
                      mk(1, 32'h1c001000 + 32'(8*k), 1, 5'(k + 1),  32'h100 + 32'(k), 0, 6'h00, 0, 0)};
      ms_to_ws_valid = 1'b1;
      #1;
      if (!ws_allowin) begin
        stalled = 1'b1;
        check("bp_stall_flags", 128'(rf_flags()), 128'(4'b1010));
      end else begin
        exp_q.push_back(tr(32'h1c001000 + 32'(8*k), 5'(k + 1),  32'h100 + 32'(k)));
        exp_q.push_back(tr(32'h1c001004 + 32'(8*k), 5'(k + 17), 32'h200 + 32'(k)));
        k++;
      end
      clk_cycle();
      cyc++;
    end
    ms_to_ws_valid = 1'b0;
    check("bp_all_accepted", 128'(k), 128'(6));
    check("bp_stall_seen", 128'(stalled), 128'(1'b1));
    repeat (20) clk_cycle();
    check("bp_trace_drained", 128'(exp_q.size()), 128'(0));

    // Reset while the FIFO holds 3 entries and a stalled bundle is in WB
    for (int b = 0; b < 3; b++) begin
      ms_to_ws_bus = {mk(1, 32'h1c002004 + 32'(8*b), 1, 5'(b + 24), 32'h400 + 32'(b), 0, 6'h00, 0, 0),
                      mk(1, 32'h1c002000 + 32'(8*b), 1, 5'(b + 8),  32'h300 + 32'(b), 0, 6'h00, 0, 0)};
      ms_to_ws_valid = 1'b1;
      #1;
      check($sformatf("rst_fill%0d_allowin", b), 128'(ws_allowin), 128'(1'b1));
      exp_q.push_back(tr(32'h1c002000 + 32'(8*b), 5'(b + 8),  32'h300 + 32'(b)));
      exp_q.push_back(tr(32'h1c002004 + 32'(8*b), 5'(b + 24), 32'h400 + 32'(b)));
      clk_cycle();
    end
    ms_to_ws_valid = 1'b0;
    #1;
    check("rst_pre_stall", 128'(ws_allowin), 128'(1'b0));
    check("rst_pre_flags", 128'(rf_flags()), 128'(4'b1010));
    reset = 1'b1;
    clk_cycle();
    exp_q.delete();
    #1;
    check("rst_mid_debug_we", 128'(debug_wb_rf_we), 128'(4'h0));
    check("rst_mid_rf_bus", 128'(rf_bus), 128'(0));
    check("rst_mid_flush", 128'(wb_flush), 128'(1'b0));
    check("rst_mid_allowin", 128'(ws_allowin), 128'(1'b1));
    clk_cycle();
    reset = 1'b0;
    repeat (4) clk_cycle();
    ms_to_ws_bus = {mk(1, 32'h1c003004, 1, 5'd2, 32'h602, 0, 6'h00, 0, 0),
                    mk(1, 32'h1c003000, 1, 5'd1, 32'h601, 0, 6'h00, 0, 0)};
    ms_to_ws_valid = 1'b1;
    exp_q.push_back(tr(32'h1c003000, 5'd1, 32'h601));
    exp_q.push_back(tr(32'h1c003004, 5'd2, 32'h602));
    clk_cycle();
    ms_to_ws_valid = 1'b0;
    #1;
    check("post_rst_flags", 128'(rf_flags()), 128'(4'b1111));
    repeat (6) clk_cycle();
    check("post_rst_trace_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
